// File: rtl/ex_mem_pkg.sv
// Shared widths, MEM control encodings and payload layout for the EX->MEM elastic stage.
package ex_mem_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int F3_W   = 3;
  localparam int MEMC_W = 2;

  typedef enum logic [MEMC_W-1:0] {
    MEMC_NONE  = 2'd0,
    MEMC_LOAD  = 2'd1,
    MEMC_STORE = 2'd2
  } memctrl_e;

  // Field order here is the bit order of the flattened slot payload (alu in the MSBs).
  typedef struct packed {
    logic [XLEN-1:0]   alu;
    logic [XLEN-1:0]   rd2;
    logic [REG_AW-1:0] a3;
    logic [F3_W-1:0]   funct3;
    logic              regwrite;
    logic [MEMC_W-1:0] memctrl;
  } ex_mem_payload_t;

  function automatic int payload_w(int xlen, int aw, int f3, int mc);
    return 2 * xlen + aw + f3 + 1 + mc;
  endfunction

endpackage

// File: rtl/ex_mem_elastic_stage_if.sv
// EX->MEM handshake bundle: upstream valid/ready + payload, downstream valid/ready + payload.
interface ex_mem_elastic_stage_if
  import ex_mem_pkg::*;
#(
  parameter int XLEN   = ex_mem_pkg::XLEN,
  parameter int REG_AW = ex_mem_pkg::REG_AW,
  parameter int F3_W   = ex_mem_pkg::F3_W,
  parameter int MEMC_W = ex_mem_pkg::MEMC_W
) ();
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_alu;
  logic [XLEN-1:0]   in_rd2;
  logic [REG_AW-1:0] in_a3;
  logic [F3_W-1:0]   in_funct3;
  logic              in_regwrite;
  logic [MEMC_W-1:0] in_memctrl;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_alu;
  logic [XLEN-1:0]   out_rd2;
  logic [REG_AW-1:0] out_a3;
  logic [F3_W-1:0]   out_funct3;
  logic              out_regwrite;
  logic [MEMC_W-1:0] out_memctrl;

  // The pipeline stage itself.
  modport slave (
    input  in_valid, in_alu, in_rd2, in_a3, in_funct3, in_regwrite, in_memctrl, out_ready,
    output in_ready, out_valid, out_alu, out_rd2, out_a3, out_funct3, out_regwrite, out_memctrl
  );

  // EX producer and MEM consumer side.
  modport master (
    output in_valid, in_alu, in_rd2, in_a3, in_funct3, in_regwrite, in_memctrl, out_ready,
    input  in_ready, out_valid, out_alu, out_rd2, out_a3, out_funct3, out_regwrite, out_memctrl
  );
endinterface

// File: rtl/ex_mem_slot.sv
// Payload holding register with load enable and asynchronous clear.
module ex_mem_slot
  import ex_mem_pkg::*;
#(
  parameter int W = ex_mem_pkg::payload_w(ex_mem_pkg::XLEN, ex_mem_pkg::REG_AW,
                                          ex_mem_pkg::F3_W, ex_mem_pkg::MEMC_W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (ld) q <= d;
  end
endmodule

// File: rtl/ex_mem_elastic_stage.sv
// EX->MEM pipeline stage: main slot plus 2nd skid slot, registered in_ready, flush squash.
// Optional saturating stall counter when EX_MEM_STALL_CNT_EN is defined.
module ex_mem_elastic_stage
  import ex_mem_pkg::*;
#(
  parameter int XLEN   = ex_mem_pkg::XLEN,
  parameter int REG_AW = ex_mem_pkg::REG_AW,
  parameter int F3_W   = ex_mem_pkg::F3_W,
  parameter int MEMC_W = ex_mem_pkg::MEMC_W,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  ex_mem_elastic_stage_if.slave  bus
`ifdef EX_MEM_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]       stall_cnt
`endif
);
  localparam int PW = payload_w(XLEN, REG_AW, F3_W, MEMC_W);

  logic          out_vld, skid_vld;
  logic          in_fire, main_free, main_ld, skid_ld;
  logic          rw_q;
  logic [PW-1:0] in_pl, main_d, main_q, skid_q;

  // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
  assign bus.in_ready = ~skid_vld;
  assign in_fire      = bus.in_valid & ~skid_vld;
  assign main_free    = ~out_vld | bus.out_ready;

  assign in_pl   = {bus.in_alu, bus.in_rd2, bus.in_a3, bus.in_funct3, bus.in_regwrite, bus.in_memctrl};
  // Skid always holds the older entry, so it wins the main slot over the input.
  assign main_d  = skid_vld ? skid_q : in_pl;
  assign main_ld = ~flush & main_free & (skid_vld | in_fire);
  assign skid_ld = ~flush & in_fire & out_vld & ~bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
    end else if (flush) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
    end else begin
      if (main_free) out_vld <= skid_vld | in_fire;
      if (skid_ld)        skid_vld <= 1'b1;
      else if (main_free) skid_vld <= 1'b0;
    end
  end

  ex_mem_slot #(.W(PW)) u_main (.clk(clk), .rst(rst), .ld(main_ld), .d(main_d), .q(main_q));
  ex_mem_slot #(.W(PW)) u_skid (.clk(clk), .rst(rst), .ld(skid_ld), .d(in_pl),  .q(skid_q));

  assign {bus.out_alu, bus.out_rd2, bus.out_a3, bus.out_funct3, rw_q, bus.out_memctrl} = main_q;
  assign bus.out_valid    = out_vld;
  // A bubble must never look like a register writer to hazard/forwarding logic.
  assign bus.out_regwrite = rw_q & out_vld;

`ifdef EX_MEM_STALL_CNT_EN
  // Only reset clears it; flush leaves the count intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (out_vld & ~bus.out_ready & ~(&stall_cnt))
      stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_ex_mem_elastic_stage.sv
// Bench for ex_mem_elastic_stage: directed vector table, async reset, randomized queue-model run.
module tb_ex_mem_elastic_stage;
  import ex_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  ex_mem_elastic_stage_if bus ();

`ifdef EX_MEM_STALL_CNT_EN
  logic [3:0] stall_cnt;
  ex_mem_elastic_stage #(.CNT_W(4)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus),
                                         .stall_cnt(stall_cnt));
`else
  ex_mem_elastic_stage #(.CNT_W(4)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input ex_mem_payload_t p, input logic ordy, input logic fl);
    bus.in_valid    = iv;
    bus.in_alu      = p.alu;
    bus.in_rd2      = p.rd2;
    bus.in_a3       = p.a3;
    bus.in_funct3   = p.funct3;
    bus.in_regwrite = p.regwrite;
    bus.in_memctrl  = p.memctrl;
    bus.out_ready   = ordy;
    flush           = fl;
  endtask

  function automatic ex_mem_payload_t mkp(input logic [31:0] alu);
    ex_mem_payload_t p;
    p.alu      = alu;
    p.rd2      = ~alu;
    p.a3       = alu[4:0];
    p.funct3   = 3'd2;
    p.regwrite = 1'b1;
    p.memctrl  = MEMC_LOAD;
    return p;
  endfunction

  function automatic ex_mem_payload_t dut_out();
    ex_mem_payload_t p;
    p = {bus.out_alu, bus.out_rd2, bus.out_a3, bus.out_funct3, bus.out_regwrite, bus.out_memctrl};
    return p;
  endfunction

  typedef struct {
    logic        iv;
    logic [31:0] alu;
    logic        ordy;
    logic        fl;
    logic        exp_ov;
    logic [31:0] exp_alu;
    logic        exp_ir;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [31:0] alu, input logic ordy,
                              input logic fl, input logic eov, input logic [31:0] ealu,
                              input logic eir);
    vec_t v;
    v.iv = iv; v.alu = alu; v.ordy = ordy; v.fl = fl;
    v.exp_ov = eov; v.exp_alu = ealu; v.exp_ir = eir;
    return v;
  endfunction

  vec_t vecs[14];
  ex_mem_payload_t q[$];
  ex_mem_payload_t p, o;

  initial begin
    // 1: streaming, 2: skid capture and drain, 3: flush with both slots full
    vecs[0]  = mk(1, 32'h1,  1, 0, 1, 32'h1, 1);
    vecs[1]  = mk(1, 32'h2,  1, 0, 1, 32'h2, 1);
    vecs[2]  = mk(1, 32'h3,  1, 0, 1, 32'h3, 1);
    vecs[3]  = mk(1, 32'h4,  1, 0, 1, 32'h4, 1);
    vecs[4]  = mk(0, 32'h0,  1, 0, 0, 32'h0, 1);
    vecs[5]  = mk(1, 32'hA,  1, 0, 1, 32'hA, 1);
    vecs[6]  = mk(1, 32'hB,  0, 0, 1, 32'hA, 0);
    vecs[7]  = mk(1, 32'hEE, 0, 0, 1, 32'hA, 0);
    vecs[8]  = mk(0, 32'h0,  1, 0, 1, 32'hB, 1);
    vecs[9]  = mk(0, 32'h0,  1, 0, 0, 32'h0, 1);
    vecs[10] = mk(1, 32'h11, 0, 0, 1, 32'h11, 1);
    vecs[11] = mk(1, 32'h22, 0, 0, 1, 32'h11, 0);
    vecs[12] = mk(1, 32'hC,  0, 1, 0, 32'h0, 1);
    vecs[13] = mk(0, 32'h0,  1, 0, 0, 32'h0, 1);

    drive(0, mkp(0), 0, 0);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_regwrite", bus.out_regwrite, 0);
    chk("rst_payload", dut_out(), 0);
`ifdef EX_MEM_STALL_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].iv, mkp(vecs[i].alu), vecs[i].ordy, vecs[i].fl);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_out_valid", i), bus.out_valid, vecs[i].exp_ov);
      chk($sformatf("vec%0d_in_ready", i), bus.in_ready, vecs[i].exp_ir);
      chk($sformatf("vec%0d_out_regwrite", i), bus.out_regwrite, vecs[i].exp_ov);
      if (vecs[i].exp_ov) chk($sformatf("vec%0d_out_alu", i), bus.out_alu, vecs[i].exp_alu);
    end

    // 4: asynchronous reset with both slots full, asserted between clock edges
    drive(1, mkp(32'h55), 0, 0);
    @(posedge clk); @(negedge clk);
    drive(1, mkp(32'h66), 0, 0);
    @(posedge clk); @(negedge clk);
    chk("pre_rst_in_ready", bus.in_ready, 0);
    drive(0, mkp(0), 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_out_regwrite", bus.out_regwrite, 0);
    chk("arst_payload", dut_out(), 0);
    chk("arst_in_ready", bus.in_ready, 1);
    #1 rst = 1'b0;
    drive(0, mkp(0), 1, 0);
    @(posedge clk); @(negedge clk);
    chk("post_rst_out_valid", bus.out_valid, 0);

    // 5: random traffic against an occupancy-queue model
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      logic iv, ordy, fl, in_fire, out_fire;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 63) == 0);
      p.alu = $urandom; p.rd2 = $urandom;
      p.a3 = 5'($urandom); p.funct3 = 3'($urandom);
      p.regwrite = 1'($urandom); p.memctrl = 2'($urandom_range(0, 2));
      drive(iv, p, ordy, fl);
      #1;
      chk("rnd_in_ready_pre", bus.in_ready, q.size() < 2);
      in_fire  = iv && (q.size() < 2);
      out_fire = (q.size() > 0) && ordy;
      if (fl) q.delete();
      else begin
        if (out_fire) void'(q.pop_front());
        if (in_fire) q.push_back(p);
      end
      @(posedge clk); @(negedge clk);
      chk("rnd_out_valid", bus.out_valid, q.size() > 0);
      chk("rnd_in_ready", bus.in_ready, q.size() < 2);
      chk("rnd_out_regwrite", bus.out_regwrite, (q.size() > 0) && q[0].regwrite);
      if (q.size() > 0) begin
        o = dut_out();
        o.regwrite = q[0].regwrite;
        chk("rnd_payload", o, q[0]);
      end
    end

`ifdef EX_MEM_STALL_CNT_EN
    // 6: stall counter saturates and survives flush
    begin
      int n;
      n = 0;
      drive(0, mkp(0), 0, 0);
      #2 rst = 1'b1;
      #1 rst = 1'b0;
      chk("cnt_after_rst", stall_cnt, 0);
      drive(1, mkp(32'h77), 0, 0);
      @(posedge clk); @(negedge clk);
      chk("cnt_first", stall_cnt, 0);
      for (int k = 0; k < 20; k++) begin
        drive(0, mkp(0), 0, 0);
        @(posedge clk); @(negedge clk);
        n = (n < 15) ? n + 1 : 15;
        chk($sformatf("cnt_stall%0d", k), stall_cnt, n);
      end
      drive(0, mkp(0), 0, 1);
      @(posedge clk); @(negedge clk);
      chk("cnt_flush_valid", bus.out_valid, 0);
      chk("cnt_after_flush", stall_cnt, 15);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
